// File: rtl/dvp_frame_capture_pkg.sv
// Shared definitions for the camera capture path and the LCD timing stage.
// Holds window defaults, pixel format and capture FSM encoding.
package dvp_frame_capture_pkg;

  localparam int unsigned IMG_W_DEF  = 200;
  localparam int unsigned IMG_H_DEF  = 164;
  localparam int unsigned RGB565_W   = 16;
  localparam int unsigned CAM_BYTE_W = 8;
  localparam int unsigned CNT_W      = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } cap_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // First camera byte lands in the upper half of the pixel.
  function automatic rgb565_t pack_rgb565(input logic [CAM_BYTE_W-1:0] hi,
                                          input logic [CAM_BYTE_W-1:0] lo);
    return rgb565_t'(RGB565_W'({hi, lo}));
  endfunction

endpackage

// File: rtl/dvp_frame_capture_if.sv
// Camera DVP bus plus image-buffer write port.
// master = capture block, slave = camera/buffer side.
interface dvp_frame_capture_if
  import dvp_frame_capture_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
);

  logic                  cam_pclk;
  logic                  cam_vsync;
  logic                  cam_href;
  logic [CAM_BYTE_W-1:0] cam_data;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  rgb565_t               wr_data;

  modport master (
    input  cam_pclk, cam_vsync, cam_href, cam_data,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output cam_pclk, cam_vsync, cam_href, cam_data,
    input  wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/dvp_in_sync.sv
// Brings the camera bus into the system clock domain and detects edges.
// Data is delayed by the same two stages so it lines up with pe.
module dvp_in_sync
  import dvp_frame_capture_pkg::*;
(
  input  logic                  clk,
  input  logic                  rest,
  input  logic                  pclk,
  input  logic                  vsync,
  input  logic                  href,
  input  logic [CAM_BYTE_W-1:0] data,
  output logic                  pe,
  output logic                  href_lvl,
  output logic                  href_rise,
  output logic                  href_fall,
  output logic                  vs_rise,
  output logic                  vs_fall,
  output logic [CAM_BYTE_W-1:0] data_al
);

  logic [2:0]            pclk_sr;
  logic [2:0]            href_sr;
  logic [2:0]            vs_sr;
  logic [CAM_BYTE_W-1:0] data_d1;
  logic [CAM_BYTE_W-1:0] data_d2;

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      pclk_sr <= '0;
      href_sr <= '0;
      vs_sr   <= '0;
      data_d1 <= '0;
      data_d2 <= '0;
    end else begin
      pclk_sr <= {pclk_sr[1:0], pclk};
      href_sr <= {href_sr[1:0], href};
      vs_sr   <= {vs_sr[1:0], vsync};
      data_d1 <= data;
      data_d2 <= data_d1;
    end
  end

  // Stage [1] is the synchronised level, stage [2] its previous value.
  assign pe        = pclk_sr[1] & ~pclk_sr[2];
  assign href_lvl  = href_sr[1];
  assign href_rise = href_sr[1] & ~href_sr[2];
  assign href_fall = ~href_sr[1] & href_sr[2];
  assign vs_rise   = vs_sr[1] & ~vs_sr[2];
  assign vs_fall   = ~vs_sr[1] & vs_sr[2];
  assign data_al   = data_d2;

endmodule

// File: rtl/dvp_frame_capture.sv
// Captures a cropped RGB565 window from a DVP camera into the image buffer.
// Pixel k of the window is written at address k (row*IMG_W + col).
module dvp_frame_capture
  import dvp_frame_capture_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned CROP_X = 0,
  parameter int unsigned CROP_Y = 0,
  parameter int unsigned ADDR_W = 16
)(
  input  logic                clk,
  input  logic                rest,
  input  logic                cap_en,
  dvp_frame_capture_if.master bus,
  output logic                frame_done,
  output logic                frame_short,
  output logic                busy
);

  localparam int unsigned       XW        = CNT_W + 1;
  localparam logic [XW-1:0]     X_LO      = XW'(CROP_X);
  localparam logic [XW-1:0]     Y_LO      = XW'(CROP_Y);
  localparam logic [XW-1:0]     W_LIM     = XW'(IMG_W);
  localparam logic [XW-1:0]     H_LIM     = XW'(IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic                  pe;
  logic                  href_lvl;
  logic                  href_rise;
  logic                  href_fall;
  logic                  vs_rise;
  logic                  vs_fall;
  logic [CAM_BYTE_W-1:0] data_al;

  dvp_in_sync u_sync (
    .clk       (clk),
    .rest      (rest),
    .pclk      (bus.cam_pclk),
    .vsync     (bus.cam_vsync),
    .href      (bus.cam_href),
    .data      (bus.cam_data),
    .pe        (pe),
    .href_lvl  (href_lvl),
    .href_rise (href_rise),
    .href_fall (href_fall),
    .vs_rise   (vs_rise),
    .vs_fall   (vs_fall),
    .data_al   (data_al)
  );

  cap_state_e            state;
  logic                  phase;
  logic [CAM_BYTE_W-1:0] hi_byte;
  logic [CNT_W-1:0]      col_cnt;
  logic [CNT_W-1:0]      line_cnt;
  logic [ADDR_W-1:0]     addr_cnt;
  logic                  last_q;

  logic          phase_eff;
  logic          byte_ok;
  logic          pix_done;
  logic [XW-1:0] col_off;
  logic [XW-1:0] line_off;
  logic          in_win;
  logic          do_wr;
  logic          last_wr;

  // An href rise in the same clk as a byte restarts pairing at that byte.
  assign phase_eff = phase & ~href_rise;
  assign byte_ok   = pe & href_lvl;
  assign pix_done  = (state == ST_ACTIVE) & byte_ok & phase_eff;

  // Offsets below the crop origin wrap to large values and fail the limit test.
  assign col_off  = XW'({1'b0, col_cnt} - X_LO);
  assign line_off = XW'({1'b0, line_cnt} - Y_LO);
  assign in_win   = (col_off < W_LIM) && (line_off < H_LIM);
  assign do_wr    = pix_done & in_win;
  assign last_wr  = do_wr & (addr_cnt == LAST_ADDR);

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state       <= ST_IDLE;
      phase       <= 1'b0;
      hi_byte     <= '0;
      col_cnt     <= '0;
      line_cnt    <= '0;
      addr_cnt    <= '0;
      last_q      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en   <= 1'b0;
      frame_short <= 1'b0;
      last_q      <= 1'b0;
      frame_done  <= last_q;

      if (href_rise) phase <= 1'b0;

      // Byte is consumed before the href fall advances the line.
      if (state == ST_ACTIVE) begin
        if (byte_ok) begin
          if (!phase_eff) begin
            hi_byte <= data_al;
            phase   <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (col_cnt != CNT_MAX) col_cnt <= col_cnt + 1'b1;
          end
        end
        if (href_fall) begin
          col_cnt <= '0;
          if (line_cnt != CNT_MAX) line_cnt <= line_cnt + 1'b1;
        end
        if (do_wr) begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= addr_cnt;
          bus.wr_data <= pack_rgb565(hi_byte, data_al);
          addr_cnt    <= addr_cnt + 1'b1;
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (cap_en) state <= ST_ARM;
        end
        ST_ARM: begin
          if (!cap_en) begin
            state <= ST_IDLE;
          end else if (vs_fall) begin
            state    <= ST_ACTIVE;
            busy     <= 1'b1;
            phase    <= 1'b0;
            col_cnt  <= '0;
            line_cnt <= '0;
            addr_cnt <= '0;
          end
        end
        ST_ACTIVE: begin
          // Completion beats a coincident vsync rise; that rise then ends the frame.
          if (last_wr) begin
            last_q <= 1'b1;
            busy   <= 1'b0;
            if (vs_rise) state <= cap_en ? ST_ARM : ST_IDLE;
            else         state <= ST_DONE;
          end else if (vs_rise) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            frame_short <= 1'b1;
          end
        end
        ST_DONE: begin
          if (vs_rise) state <= cap_en ? ST_ARM : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dvp_frame_capture.sv
// Directed bench for dvp_frame_capture using a reduced 4x3 window cropped
// at (1,1) from a 6-pixel x 5-line camera frame.
module tb_dvp_frame_capture;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int CX    = 1;
  localparam int CY    = 1;
  localparam int NPIX  = 6;
  localparam int NLINE = 5;

  logic clk = 1'b0;
  logic rest;
  logic cap_en;
  logic frame_done;
  logic frame_short;
  logic busy;

  dvp_frame_capture_if #(.ADDR_W(16)) bus ();

  dvp_frame_capture #(
    .IMG_W (W),
    .IMG_H (H),
    .CROP_X(CX),
    .CROP_Y(CY),
    .ADDR_W(16)
  ) dut (
    .clk        (clk),
    .rest       (rest),
    .cap_en     (cap_en),
    .bus        (bus),
    .frame_done (frame_done),
    .frame_short(frame_short),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Write recorder, sampled on the falling edge.
  int          cyc = 0;
  logic [15:0] rec_addr[$];
  logic [15:0] rec_data[$];
  int          n_done = 0;
  int          n_short = 0;
  int          n_consec = 0;
  int          last_wr_cyc = 0;
  int          done_cyc = 0;
  bit          prev_wr = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.wr_en === 1'b1) begin
      rec_addr.push_back(16'(bus.wr_addr));
      rec_data.push_back(16'(bus.wr_data));
      last_wr_cyc = cyc;
      if (prev_wr) n_consec = n_consec + 1;
    end
    prev_wr = (bus.wr_en === 1'b1);
    if (frame_done === 1'b1) begin
      n_done   = n_done + 1;
      done_cyc = cyc;
    end
    if (frame_short === 1'b1) n_short = n_short + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int k);
    return {8'(CY + k / W), 8'(CX + k % W)};
  endfunction

  task automatic check_writes(input string name, input int base, input int n);
    check({name, "_count"}, 32'(rec_addr.size() - base), 32'(n));
    for (int k = 0; k < n && base + k < rec_addr.size(); k++) begin
      check($sformatf("%s_addr%0d", name, k), 32'(rec_addr[base+k]), 32'(k));
      check($sformatf("%s_data%0d", name, k), 32'(rec_data[base+k]), 32'(exp_pix(k)));
    end
  endtask

  // One camera byte: pclk low for 2 clk, then high for 2 clk.
  task automatic cam_byte(input logic [7:0] b);
    bus.cam_data = b;
    bus.cam_pclk = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.cam_pclk = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic idle_pclk(input int n);
    for (int i = 0; i < n; i++) cam_byte(8'h00);
  endtask

  task automatic send_pix(input int l, input int p);
    cam_byte(8'(l));
    cam_byte(8'(p));
  endtask

  task automatic end_line();
    bus.cam_href = 1'b0;
    idle_pclk(2);
  endtask

  task automatic cam_line(input int l, input bit odd);
    bus.cam_href = 1'b1;
    for (int p = 0; p < NPIX; p++) send_pix(l, p);
    if (odd) cam_byte(8'hEE);
    end_line();
  endtask

  task automatic vs_low();
    bus.cam_vsync = 1'b0;
    idle_pclk(3);
  endtask

  task automatic vs_high();
    bus.cam_vsync = 1'b1;
    idle_pclk(3);
  endtask

  int base;
  int d0;
  int s0;

  initial begin
    rest          = 1'b1;
    cap_en        = 1'b0;
    bus.cam_pclk  = 1'b0;
    bus.cam_vsync = 1'b1;
    bus.cam_href  = 1'b0;
    bus.cam_data  = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_short", 32'(frame_short), 32'd0);
    rest = 1'b0;
    idle_pclk(3);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_writes", 32'(rec_addr.size()), 32'd0);

    // Full frame.
    cap_en = 1'b1;
    idle_pclk(1);
    check("arm_busy", 32'(busy), 32'd0);
    base = rec_addr.size(); d0 = n_done; s0 = n_short;
    vs_low();
    check("act_busy", 32'(busy), 32'd1);
    for (int l = 0; l < NLINE; l++) cam_line(l, 1'b0);
    check("full_busy_end", 32'(busy), 32'd0);
    vs_high();
    check_writes("full", base, W * H);
    check("full_done", 32'(n_done - d0), 32'd1);
    check("full_short", 32'(n_short - s0), 32'd0);
    check("full_done_lat", 32'(done_cyc - last_wr_cyc), 32'd1);

    // Back-to-back frame, odd byte count per line, latency probe.
    base = rec_addr.size(); d0 = n_done;
    vs_low();
    cam_line(0, 1'b1);
    bus.cam_href = 1'b1;
    send_pix(1, 0);
    cam_byte(8'd1);
    cam_byte(8'd1);
    check("lat_early", 32'(bus.wr_en), 32'd0);
    @(posedge clk); #1;
    check("lat_wr_en", 32'(bus.wr_en), 32'd1);
    check("lat_addr", 32'(bus.wr_addr), 32'd0);
    check("lat_data", 32'(bus.wr_data), 32'h0101);
    @(posedge clk); #1;
    check("lat_pulse", 32'(bus.wr_en), 32'd0);
    for (int p = 2; p < NPIX; p++) send_pix(1, p);
    cam_byte(8'hEE);
    end_line();
    for (int l = 2; l < NLINE; l++) cam_line(l, 1'b1);
    vs_high();
    check_writes("odd", base, W * H);
    check("odd_done", 32'(n_done - d0), 32'd1);

    // Short frame: vsync rises after two lines.
    base = rec_addr.size(); d0 = n_done; s0 = n_short;
    vs_low();
    cam_line(0, 1'b0);
    cam_line(1, 1'b0);
    vs_high();
    check_writes("short", base, W);
    check("short_pulse", 32'(n_short - s0), 32'd1);
    check("short_no_done", 32'(n_done - d0), 32'd0);
    check("short_busy", 32'(busy), 32'd0);

    // cap_en dropped mid-frame: frame finishes, next frame ignored.
    base = rec_addr.size(); d0 = n_done;
    vs_low();
    cam_line(0, 1'b0);
    cam_line(1, 1'b0);
    cap_en = 1'b0;
    for (int l = 2; l < NLINE; l++) cam_line(l, 1'b0);
    vs_high();
    check_writes("drop", base, W * H);
    check("drop_done", 32'(n_done - d0), 32'd1);
    base = rec_addr.size();
    vs_low();
    check("drop_next_busy", 32'(busy), 32'd0);
    for (int l = 0; l < NLINE; l++) cam_line(l, 1'b0);
    vs_high();
    check("drop_next_writes", 32'(rec_addr.size() - base), 32'd0);

    // Reset mid-line while a write is on the port.
    cap_en = 1'b1;
    idle_pclk(1);
    vs_low();
    cam_line(0, 1'b0);
    bus.cam_href = 1'b1;
    for (int p = 0; p < 3; p++) send_pix(1, p);
    @(posedge clk); #1;
    check("mid_wr_en", 32'(bus.wr_en), 32'd1);
    base = rec_addr.size();
    rest = 1'b1;
    #1;
    check("rstmid_wr_en", 32'(bus.wr_en), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rest = 1'b0;
    for (int p = 3; p < NPIX; p++) send_pix(1, p);
    end_line();
    for (int l = 2; l < NLINE; l++) cam_line(l, 1'b0);
    check("rstmid_busy_after", 32'(busy), 32'd0);
    vs_high();
    check("rstmid_writes", 32'(rec_addr.size() - base), 32'd0);
    base = rec_addr.size(); d0 = n_done;
    vs_low();
    for (int l = 0; l < NLINE; l++) cam_line(l, 1'b0);
    vs_high();
    check_writes("restart", base, W * H);
    check("restart_done", 32'(n_done - d0), 32'd1);

    check("no_consec_wr", 32'(n_consec), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
